miriscv_mem_arbiter: RTL
========================

Name: miriscv_mem_arbiter

Overview:
Shares one memory port between the instruction fetch path and the load/store path. Arbitrates requests and tracks outstanding transactions in an in-order source-ID FIFO. Routes each response back to the requester that issued it. Discards fetch responses made stale by a pipeline redirect (flush). Sits between the fetch unit / LSU and the single external memory interface.

Parameters:
XLEN, 32, data/address width
MAX_OUTSTANDING, 2, depth of the outstanding-transaction FIFO (power of two, >=1)

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous reset, active-low
instr_req_i  in  1  fetch request
instr_addr_i  in  XLEN  fetch address
instr_flush_i  in  1  redirect: drop all outstanding fetch responses
instr_gnt_o  out  1  fetch request accepted this cycle
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  XLEN  fetch response data
data_req_i  in  1  LSU request
data_we_i  in  1  LSU write enable
data_be_i  in  XLEN/8  LSU byte enables
data_addr_i  in  XLEN  LSU address
data_wdata_i  in  XLEN  LSU write data
data_gnt_o  out  1  LSU request accepted this cycle
data_rvalid_o  out  1  LSU response valid (reads and writes)
data_rdata_o  out  XLEN  LSU read data
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  XLEN/8  memory byte enables
mem_addr_o  out  XLEN  memory address
mem_wdata_o  out  XLEN  memory write data
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  XLEN  memory response data
protocol_err_o  out  1  sticky: mem_rvalid_i received with FIFO empty

Behaviour:
- Reset (arstn_i low, asynchronous): FIFO empty, all discard bits 0, protocol_err_o=0, RR pointer = instr. All gnt/rvalid/mem_req outputs are 0 while reset is held. Reset mid-transaction abandons in-flight entries; late responses after reset set protocol_err_o.
- Memory contract: exactly one mem_rvalid_i per granted request, in grant order, at least 1 cycle after the grant. Write requests also return an rvalid.
- Arbitration is combinational:
  - sel_data = data_req_i & (~instr_req_i | priority favours data).
  - The default priority is fixed: data beats instr.
  - mem_req_o = (instr_req_i | data_req_i) & ~full.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are muxed from the selected requester.
  - For an instr selection: mem_we_o=0 and mem_be_o = all ones.
- Grant: accept = mem_req_o & mem_gnt_i. Only the selected requester's gnt_o goes high. A requester holds req and its payload stable until gnt.
- FIFO entry = {src (0=instr, 1=data), discard}.
  - Push on accept with src = selected requester.
  - Pop on mem_rvalid_i when not empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Full blocks new requests (mem_req_o=0), even when a pop happens the same cycle.
- Response routing, combinational with 0 added latency:
  - instr_rvalid_o = mem_rvalid_i & ~empty & head.src==instr & ~head.discard.
  - data_rvalid_o = mem_rvalid_i & ~empty & head.src==data.
  - Both rdata outputs = mem_rdata_i.
- Flush: when instr_flush_i=1, every valid entry with src=instr gets discard=1 at the clock edge. This includes an instr entry pushed in the same cycle. Data entries are untouched. A discarded entry is still popped on its rvalid but produces no instr_rvalid_o.
- Flush on the same cycle as a head pop of an instr entry: that response is still delivered, because the discard is applied at the edge after routing.
- mem_rvalid_i while empty: no rvalid to either side; protocol_err_o set to 1 and held until reset.

Optional Feature:
MIRISCV_ARB_RR_EN
- Defined: round-robin arbitration. When both requesters are active, the one not most recently granted wins. The 1-bit last-granted pointer updates on every accept.
- Undefined: fixed priority, data always wins. The pointer logic is absent.

Test Plan:
- Only instr_req_i=1, addr=0x100, mem_gnt_i=1, rvalid 1 cycle later with rdata=0xDEADBEEF -> instr_gnt_o=1 at cycle 0; instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF at cycle 1; data_rvalid_o=0.
- Both requesting, data write to addr=0x200, be=0xF, wdata=0x55, fixed priority -> data granted first with mem_we_o=1 and mem_addr_o=0x200; instr granted next cycle. Responses route data then instr, in order.
- Issue 2 instr requests (addr 0x0, 0x4), then instr_flush_i=1 before either response -> both rvalids popped, instr_rvalid_o stays 0, FIFO empty afterwards.
- MAX_OUTSTANDING=2, mem_rvalid_i held low, 3 back-to-back requests -> 2 grants, then mem_req_o=0. After one rvalid, the third request is granted the following cycle.
- mem_rvalid_i=1 with empty FIFO -> no rvalid outputs; protocol_err_o=1 and stays 1 until arstn_i=0.
- MIRISCV_ARB_RR_EN defined, both requesting continuously for 4 cycles -> grants alternate instr, data, instr, data.

Source files
------------

// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - shares one memory port between instruction fetch and load/store
//
// Arbitrates fetch and LSU requests onto a single memory port. Each accepted
// request is recorded in an in-order source FIFO so that its response can be
// routed back to the requester that issued it. Fetch responses made stale by
// a redirect (instr_flush_i) are popped but not delivered.
//
// Optional feature macro: MIRISCV_ARB_RR_EN
//   defined   - round-robin between fetch and LSU when both request
//   undefined - fixed priority, LSU always wins
//
// Ports:
//   clk_i, arstn_i              clock, asynchronous active-low reset
//   instr_req_i/addr_i          fetch request and address
//   instr_flush_i               drop all outstanding fetch responses
//   instr_gnt_o                 fetch request accepted this cycle
//   instr_rvalid_o/rdata_o      fetch response
//   data_req_i/we_i/be_i/addr_i/wdata_i   LSU request and payload
//   data_gnt_o                  LSU request accepted this cycle
//   data_rvalid_o/rdata_o       LSU response (reads and writes)
//   mem_req_o/we_o/be_o/addr_o/wdata_o    memory request and payload
//   mem_gnt_i                   memory accepted request
//   mem_rvalid_i/rdata_i        memory response
//   protocol_err_o              sticky: response arrived with nothing outstanding

module miriscv_mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  input  logic              instr_flush_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,

  output logic              protocol_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Outstanding-transaction FIFO: src (0=instr, 1=data) and discard per slot
  logic [MAX_OUTSTANDING-1:0] src_q;
  logic [MAX_OUTSTANDING-1:0] disc_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       protocol_err_q;

  logic full, empty;
  logic prio_data;
  logic sel_data;
  logic accept;
  logic pop;
  logic head_src, head_disc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    else                                  return p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

`ifdef MIRISCV_ARB_RR_EN
  // Set when the LSU should win the next contested cycle; after every accept
  // the requester that was not granted gets the advantage.
  logic prio_data_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)    prio_data_q <= 1'b0;
    else if (accept) prio_data_q <= ~sel_data;
  end

  assign prio_data = prio_data_q;
`else
  assign prio_data = 1'b1;
`endif

  assign sel_data = data_req_i & (~instr_req_i | prio_data);

  // Gated with the reset so no request escapes while reset is held.
  // Full blocks requests even when a pop is happening this cycle.
  assign mem_req_o = arstn_i & (instr_req_i | data_req_i) & ~full;
  assign accept    = mem_req_o & mem_gnt_i;

  assign instr_gnt_o = accept & ~sel_data;
  assign data_gnt_o  = accept & sel_data;

  assign mem_we_o    = sel_data & data_we_i;
  assign mem_be_o    = sel_data ? data_be_i : {(XLEN/8){1'b1}};
  assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = data_wdata_i;

  assign head_src  = src_q[rd_ptr_q];
  assign head_disc = disc_q[rd_ptr_q];
  assign pop       = mem_rvalid_i & ~empty;

  assign instr_rvalid_o = pop & ~head_src & ~head_disc;
  assign data_rvalid_o  = pop & head_src;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      src_q          <= '0;
      disc_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      // Flush marks every instr slot; empty slots with a stale src are
      // harmless because a push rewrites both fields of its slot.
      if (instr_flush_i) disc_q <= disc_q | ~src_q;

      if (accept) begin
        src_q[wr_ptr_q]  <= sel_data;
        disc_q[wr_ptr_q] <= instr_flush_i & ~sel_data;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end

      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (mem_rvalid_i && empty) protocol_err_q <= 1'b1;
    end
  end

endmodule
